// File: rtl/ahb_arbiter_m2.sv
// Two-master AHB arbiter with burst/lock-aware handover and fixed priority.
// Define AMBA_AHB_ARB_RR_EN to switch the priority to round-robin.
module ahb_arbiter_m2 #(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HBUSREQ_0,
    input  logic       HLOCK_0,
    input  logic       HBUSREQ_1,
    input  logic       HLOCK_1,
    output logic       HGRANT_0,
    output logic       HGRANT_1,
    output logic [3:0] HMASTER,
    output logic       HMASTLOCK
);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic       DEF_M   = (DEFAULT_MASTER != 0);
    localparam logic [1:0] DEF_GNT = DEF_M ? 2'b10 : 2'b01;

    logic [3:0] beats_q, beats_d;
    logic [3:0] burst_len;
    logic [1:0] gnt_q, gnt_d;
    logic       hmaster_q, hmaster_d;
    logic       mastlock_q, mastlock_d;
    logic [1:0] req;
    logic       owner_lock;
    logic       arb_pt;
    logic       winner;

    assign req        = {HBUSREQ_1, HBUSREQ_0};
    assign owner_lock = gnt_q[1] ? HLOCK_1 : HLOCK_0;

    always_comb begin
        unique case (HBURST)
            3'd2, 3'd3: burst_len = 4'd3;
            3'd4, 3'd5: burst_len = 4'd7;
            3'd6, 3'd7: burst_len = 4'd15;
            default:    burst_len = 4'd0;
        endcase
    end

    always_comb begin
        beats_d = beats_q;
        if (HREADY) begin
            unique case (HTRANS)
                TR_NONSEQ: beats_d = burst_len;
                TR_SEQ: begin
                    if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
                end
                TR_IDLE:   beats_d = 4'd0;
                TR_BUSY:   beats_d = beats_q;
            endcase
        end
    end

    // Handover only after the last fixed-burst beat and outside locks.
    assign arb_pt = HREADY && (beats_d == 4'd0) && !owner_lock;

`ifdef AMBA_AHB_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (req[~last_q])    winner = ~last_q;
        else if (req[last_q]) winner = last_q;
        else                  winner = DEF_M;
    end

    assign last_d = (hmaster_d != hmaster_q) ? hmaster_d : last_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) last_q <= DEF_M;
        else          last_q <= last_d;
    end
`else
    always_comb begin
        if (req[0])      winner = 1'b0;
        else if (req[1]) winner = 1'b1;
        else             winner = DEF_M;
    end
`endif

    always_comb begin
        gnt_d = gnt_q;
        if (arb_pt) gnt_d = winner ? 2'b10 : 2'b01;
    end

    assign hmaster_d  = HREADY ? gnt_q[1]   : hmaster_q;
    assign mastlock_d = HREADY ? owner_lock : mastlock_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_q    <= 4'd0;
            gnt_q      <= DEF_GNT;
            hmaster_q  <= DEF_M;
            mastlock_q <= 1'b0;
        end else begin
            beats_q    <= beats_d;
            gnt_q      <= gnt_d;
            hmaster_q  <= hmaster_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign HGRANT_0  = gnt_q[0];
    assign HGRANT_1  = gnt_q[1];
    assign HMASTER   = {3'b000, hmaster_q};
    assign HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter_m2.sv
// Directed bench for ahb_arbiter_m2 (default fixed-priority build).
module tb_ahb_arbiter_m2;
    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HBUSREQ_0, HLOCK_0, HBUSREQ_1, HLOCK_1;
    logic       HGRANT_0, HGRANT_1;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    int checks   = 0;
    int failures = 0;

    ahb_arbiter_m2 #(.DEFAULT_MASTER(0)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HBUSREQ_0 (HBUSREQ_0),
        .HLOCK_0   (HLOCK_0),
        .HBUSREQ_1 (HBUSREQ_1),
        .HLOCK_1   (HLOCK_1),
        .HGRANT_0  (HGRANT_0),
        .HGRANT_1  (HGRANT_1),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        chk({tag, "_g0"}, {3'b0, HGRANT_0}, {3'b0, g0});
        chk({tag, "_g1"}, {3'b0, HGRANT_1}, {3'b0, g1});
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HTRANS = 2'd0; HBURST = 3'd0;
        HBUSREQ_0 = 1'b0; HLOCK_0 = 1'b0;
        HBUSREQ_1 = 1'b0; HLOCK_1 = 1'b0;
        #12;
        chk_gnt("rst", 1'b1, 1'b0);
        chk("rst_hm", HMASTER, 4'd0);
        chk("rst_lk", {3'b0, HMASTLOCK}, 4'd0);
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_gnt("idle_hold", 1'b1, 1'b0);
        end

        // Lone request from master 1
        HBUSREQ_1 = 1'b1;
        step(); chk_gnt("req1_e1", 1'b0, 1'b1); chk("req1_hm1", HMASTER, 4'd0);
        step(); chk("req1_hm2", HMASTER, 4'd1);

        // INCR4 by master 1, master 0 requests on beat 2
        HTRANS = 2'd2; HBURST = 3'd3;
        step(); chk_gnt("i4_b1", 1'b0, 1'b1);
        HTRANS = 2'd3; HBUSREQ_0 = 1'b1;
        step(); chk_gnt("i4_b2", 1'b0, 1'b1);
        step(); chk_gnt("i4_b3", 1'b0, 1'b1);
        step(); chk_gnt("i4_b4", 1'b1, 1'b0); chk("i4_b4_hm", HMASTER, 4'd1);
        HTRANS = 2'd0;
        step(); chk("i4_hand_hm", HMASTER, 4'd0);

        // Back to master 1
        HBUSREQ_0 = 1'b0;
        step(); chk_gnt("back1", 1'b0, 1'b1);
        step(); chk("back1_hm", HMASTER, 4'd1);

        // INCR4 with owner dropping request on NONSEQ, 2 waits on beat 3
        HTRANS = 2'd2; HBURST = 3'd3; HBUSREQ_1 = 1'b0;
        step(); chk_gnt("w_b1", 1'b0, 1'b1);
        HTRANS = 2'd3; HBUSREQ_0 = 1'b1;
        step(); chk_gnt("w_b2", 1'b0, 1'b1);
        HREADY = 1'b0;
        step(); chk_gnt("w_ws1", 1'b0, 1'b1);
        step(); chk_gnt("w_ws2", 1'b0, 1'b1);
        HREADY = 1'b1;
        step(); chk_gnt("w_b3", 1'b0, 1'b1);
        step(); chk_gnt("w_b4", 1'b1, 1'b0); chk("w_b4_hm", HMASTER, 4'd1);
        HTRANS = 2'd0;
        step(); chk("w_hand_hm", HMASTER, 4'd0);

        // Locked sequence by master 1
        HBUSREQ_0 = 1'b0; HBUSREQ_1 = 1'b1; HLOCK_1 = 1'b1;
        step(); chk_gnt("lk_gnt", 1'b0, 1'b1);
        chk("lk_ml0", {3'b0, HMASTLOCK}, 4'd0);
        step(); chk("lk_hm", HMASTER, 4'd1);
        chk("lk_ml1", {3'b0, HMASTLOCK}, 4'd1);
        HBUSREQ_0 = 1'b1; HTRANS = 2'd2; HBURST = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_gnt("lk_single", 1'b0, 1'b1);
            chk("lk_single_ml", {3'b0, HMASTLOCK}, 4'd1);
        end
        HLOCK_1 = 1'b0;
        step(); chk_gnt("lk_rel", 1'b1, 1'b0);
        chk("lk_rel_ml", {3'b0, HMASTLOCK}, 4'd0);
        chk("lk_rel_hm", HMASTER, 4'd1);
        HREADY = 1'b0;
        step(); chk("lk_ws_hm", HMASTER, 4'd1);
        chk_gnt("lk_ws", 1'b1, 1'b0);
        HREADY = 1'b1; HTRANS = 2'd0;
        step(); chk("lk_hand_hm", HMASTER, 4'd0);

        // Both requesting, single transfers: master 0 keeps the bus
        HTRANS = 2'd2; HBURST = 3'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_gnt("both", 1'b1, 1'b0);
            chk("both_hm", HMASTER, 4'd0);
        end

        // Reset mid-WRAP8 owned by master 1
        HBUSREQ_0 = 1'b0; HTRANS = 2'd0;
        step(); chk_gnt("wr_gnt", 1'b0, 1'b1);
        step(); chk("wr_hm", HMASTER, 4'd1);
        HTRANS = 2'd2; HBURST = 3'd4;
        step(); chk_gnt("wr_b1", 1'b0, 1'b1);
        HTRANS = 2'd3;
        step(); chk_gnt("wr_b2", 1'b0, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk_gnt("arst", 1'b1, 1'b0);
        chk("arst_hm", HMASTER, 4'd0);
        chk("arst_ml", {3'b0, HMASTLOCK}, 4'd0);
        #2 HRESETn = 1'b1;
        step(); chk_gnt("post_rst", 1'b0, 1'b1);
        chk("post_rst_hm", HMASTER, 4'd0);
        step(); chk("post_rst_hm2", HMASTER, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
